// File: rtl/wb_write_buffer.sv
// Write-back buffer: in-order FIFO of pending register writes that drains into the
// register-file write port when it is free, and forwards the youngest pending value
// for two read-stage source registers.
module wb_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_dest,
    input  logic [31:0]              in_val,
    input  logic                     drain_en,
    output logic                     WB_en,
    output logic [3:0]               WB_dest,
    output logic [31:0]              WB_val,
    input  logic [3:0]               src1,
    input  logic [3:0]               src2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [31:0]              fwd1,
    output logic [31:0]              fwd2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Register 15 is the PC: writes to it are swallowed and it never forwards.
    localparam logic [3:0] PcReg = 4'hF;

    logic [3:0]    mem_dest_q [DEPTH];
    logic [31:0]   mem_val_q  [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Status and handshake come from registered state only.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        in_ready = !full;
        count    = count_q;
        push     = in_valid && in_ready && (in_dest != PcReg);
        pop      = !empty && drain_en;
        WB_en    = pop;
        WB_dest  = empty ? 4'h0 : mem_dest_q[rd_ptr_q];
        WB_val   = empty ? 32'h0 : mem_val_q[rd_ptr_q];
    end

    // Pointer and occupancy next-state; pointers wrap naturally as DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are masked by count so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dest_q[wr_ptr_q] <= in_dest;
            mem_val_q[wr_ptr_q]  <= in_val;
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = 32'h0;
        fwd2 = 32'h0;
        idx  = rd_ptr_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (src1 != PcReg && mem_dest_q[idx] == src1) begin
                    hit1 = 1'b1;
                    fwd1 = mem_val_q[idx];
                end
                if (src2 != PcReg && mem_dest_q[idx] == src2) begin
                    hit2 = 1'b1;
                    fwd2 = mem_val_q[idx];
                end
            end
        end
    end

endmodule
